// File: rtl/ex_mem_buf.sv
// ex_mem_buf -- two-entry skid buffer between the execute unit and the memory stage.
//
// Purpose:
//   Holds EXU writeback beats {pc, we, addr, data} in a main entry (which drives the
//   outputs) and a skid entry. ex_ready_o comes straight from a register, so there is
//   no combinational path from mem_ready_i back to the EXU. It also keeps a saturating
//   count of the cycles during which mem back-pressures a valid beat.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   ex_valid_i   in   EXU beat valid
//   ex_ready_o   out  buffer can accept a beat (skid entry empty)
//   pc_i         in   [31:0] pc of the EXU instruction
//   rd_we_i      in   writeback enable
//   rd_addr_i    in   [4:0]  destination register
//   rd_data_i    in   [31:0] writeback data
//   flush_i      in   discard buffered beats and the same-cycle input beat
//   mem_valid_o  out  head beat valid toward mem
//   mem_ready_i  in   mem accepts the head beat
//   pc_o, rd_we_o, rd_addr_o, rd_data_o  out  head beat (rd_we_o cleared for x0)
//   stall_cnt_o  out  [15:0] saturating back-pressure cycle count
//
// Optional feature (macro EX_MEM_FWD_EN):
//   fwd_we_o/fwd_addr_o/fwd_data_o mirror the head beat, and
//   fwd_skid_we_o/fwd_skid_addr_o/fwd_skid_data_o expose the skid entry,
//   both with the x0 write suppression, for ID-stage bypassing.
module ex_mem_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] pc_i,
  input  logic        rd_we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        flush_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] pc_o,
  output logic        rd_we_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic [15:0] stall_cnt_o
`ifdef EX_MEM_FWD_EN
  ,
  output logic        fwd_we_o,
  output logic [4:0]  fwd_addr_o,
  output logic [31:0] fwd_data_o,
  output logic        fwd_skid_we_o,
  output logic [4:0]  fwd_skid_addr_o,
  output logic [31:0] fwd_skid_data_o
`endif
);

  logic        main_valid_q, main_valid_d;
  logic [31:0] main_pc_q,    main_pc_d;
  logic        main_we_q,    main_we_d;
  logic [4:0]  main_addr_q,  main_addr_d;
  logic [31:0] main_data_q,  main_data_d;

  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q,    skid_pc_d;
  logic        skid_we_q,    skid_we_d;
  logic [4:0]  skid_addr_q,  skid_addr_d;
  logic [31:0] skid_data_q,  skid_data_d;

  logic [15:0] stall_cnt_q,  stall_cnt_d;

  logic accept;
  logic pop;

  assign ex_ready_o = ~skid_valid_q;
  assign accept     = ex_valid_i & ex_ready_o & ~flush_i;
  assign pop        = main_valid_q & mem_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_we_d    = main_we_q;
    main_addr_d  = main_addr_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_we_d    = skid_we_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;

    if (flush_i) begin
      // Entry fields are left alone so the outputs keep showing the last head beat.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // ex_ready_o is low here, so no accept can coincide with this case.
      if (pop) begin
        main_pc_d    = skid_pc_q;
        main_we_d    = skid_we_q;
        main_addr_d  = skid_addr_q;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept && (!main_valid_q || pop)) begin
      main_valid_d = 1'b1;
      main_pc_d    = pc_i;
      main_we_d    = rd_we_i;
      main_addr_d  = rd_addr_i;
      main_data_d  = rd_data_i;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = pc_i;
      skid_we_d    = rd_we_i;
      skid_addr_d  = rd_addr_i;
      skid_data_d  = rd_data_i;
    end else if (pop) begin
      main_valid_d = 1'b0;
    end
  end

  // Counts back-pressure independently of flush; holds at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid_q && !mem_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_we_q    <= 1'b0;
      main_addr_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_we_q    <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_we_q    <= main_we_d;
      main_addr_q  <= main_addr_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_we_q    <= skid_we_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign mem_valid_o = main_valid_q;
  assign pc_o        = main_pc_q;
  assign rd_addr_o   = main_addr_q;
  assign rd_data_o   = main_data_q;
  // Writes to x0 flow through as ordinary beats but never request a writeback.
  assign rd_we_o     = main_valid_q & main_we_q & (|main_addr_q);
  assign stall_cnt_o = stall_cnt_q;

`ifdef EX_MEM_FWD_EN
  assign fwd_we_o        = rd_we_o;
  assign fwd_addr_o      = rd_addr_o;
  assign fwd_data_o      = rd_data_o;
  assign fwd_skid_we_o   = skid_valid_q & skid_we_q & (|skid_addr_q);
  assign fwd_skid_addr_o = skid_addr_q;
  assign fwd_skid_data_o = skid_data_q;
`endif

endmodule

// File: tb/tb_ex_mem_buf.sv
module tb_ex_mem_buf;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] pc_i;
  logic        rd_we_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        flush_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] pc_o;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic [15:0] stall_cnt_o;
`ifdef EX_MEM_FWD_EN
  logic        fwd_we_o, fwd_skid_we_o;
  logic [4:0]  fwd_addr_o, fwd_skid_addr_o;
  logic [31:0] fwd_data_o, fwd_skid_data_o;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: an ordered queue of at most two beats, plus the last beat shown.
  beat_t       mq[$];
  beat_t       last_head = '0;
  logic [15:0] m_stall = '0;

  ex_mem_buf dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_valid_i  (ex_valid_i),
    .ex_ready_o  (ex_ready_o),
    .pc_i        (pc_i),
    .rd_we_i     (rd_we_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_i   (rd_data_i),
    .flush_i     (flush_i),
    .mem_valid_o (mem_valid_o),
    .mem_ready_i (mem_ready_i),
    .pc_o        (pc_o),
    .rd_we_o     (rd_we_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .stall_cnt_o (stall_cnt_o)
`ifdef EX_MEM_FWD_EN
    ,
    .fwd_we_o        (fwd_we_o),
    .fwd_addr_o      (fwd_addr_o),
    .fwd_data_o      (fwd_data_o),
    .fwd_skid_we_o   (fwd_skid_we_o),
    .fwd_skid_addr_o (fwd_skid_addr_o),
    .fwd_skid_data_o (fwd_skid_data_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    beat_t in;
    bit    ready, acc, pop;
    in = '{pc: pc_i, we: rd_we_i, addr: rd_addr_i, data: rd_data_i};
    if (!rst_n) begin
      mq.delete();
      last_head = '0;
      m_stall   = '0;
    end else begin
      ready = (mq.size() < 2);
      pop   = (mq.size() > 0) && mem_ready_i;
      acc   = ex_valid_i && ready && !flush_i;
      if ((mq.size() > 0) && !mem_ready_i && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if (flush_i) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(in);
      end
      if (mq.size() > 0) last_head = mq[0];
    end
  endtask

  task automatic check_model();
    beat_t h;
    bit    v;
    v = (mq.size() > 0);
    h = last_head;
    chk("mem_valid", {31'd0, mem_valid_o}, {31'd0, v});
    chk("ex_ready", {31'd0, ex_ready_o}, {31'd0, (mq.size() < 2)});
    chk("pc", pc_o, h.pc);
    chk("rd_we", {31'd0, rd_we_o}, {31'd0, v && h.we && (h.addr != 5'd0)});
    chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, h.addr});
    chk("rd_data", rd_data_o, h.data);
    chk("stall_cnt", {16'd0, stall_cnt_o}, {16'd0, m_stall});
  endtask

  task automatic cycle(input bit do_check);
    @(posedge clk);
    model_edge();
    #1;
    if (do_check) check_model();
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit we,
                       input logic [4:0] a, input logic [31:0] d);
    ex_valid_i = v;
    pc_i       = pc;
    rd_we_i    = we;
    rd_addr_i  = a;
    rd_data_i  = d;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b1;
    drive(1'b1, 32'hDEAD, 1'b1, 5'd3, 32'hBEEF);

    // Reset with a valid beat presented: nothing may be captured.
    cycle(1'b1);
    cycle(1'b1);
    chk("rst_mem_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("rst_pc", pc_o, 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1);
    chk("post_rst_data", rd_data_o, 32'd0);

    // Single beat, 1-cycle latency, gone the cycle after.
    drive(1'b1, 32'h100, 1'b1, 5'd5, 32'hA5A5A5A5);
    cycle(1'b1);
    chk("beat_valid", {31'd0, mem_valid_o}, 32'd1);
    chk("beat_we", {31'd0, rd_we_o}, 32'd1);
    chk("beat_addr", {27'd0, rd_addr_o}, 32'd5);
    chk("beat_data", rd_data_o, 32'hA5A5A5A5);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b1);
    chk("beat_gone", {31'd0, mem_valid_o}, 32'd0);

    // Back-pressure: 1,2 accepted, 3 held until space frees up.
    mem_ready_i = 1'b0;
    drive(1'b1, 32'h200, 1'b1, 5'd1, 32'd1);
    cycle(1'b1);
    drive(1'b1, 32'h204, 1'b1, 5'd2, 32'd2);
    cycle(1'b1);
    chk("bp_ready_low", {31'd0, ex_ready_o}, 32'd0);
    drive(1'b1, 32'h208, 1'b1, 5'd3, 32'd3);
    cycle(1'b1);
    chk("bp_head1", rd_data_o, 32'd1);
    chk("bp_stall", {16'd0, stall_cnt_o}, 32'd2);
    mem_ready_i = 1'b1;
    cycle(1'b1);
    chk("bp_head2", rd_data_o, 32'd2);
    cycle(1'b1);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("bp_head3", rd_data_o, 32'd3);
    cycle(1'b1);
    chk("bp_drained", {31'd0, mem_valid_o}, 32'd0);

    // Write to x0 passes through with we cleared.
    drive(1'b1, 32'h300, 1'b1, 5'd0, 32'hFFFFFFFF);
    cycle(1'b1);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("x0_valid", {31'd0, mem_valid_o}, 32'd1);
    chk("x0_we", {31'd0, rd_we_o}, 32'd0);
    cycle(1'b1);

    // Fill both entries, then flush with a beat offered.
    mem_ready_i = 1'b0;
    drive(1'b1, 32'h400, 1'b1, 5'd7, 32'h12);
    cycle(1'b1);
    drive(1'b1, 32'h404, 1'b1, 5'd9, 32'h34);
    cycle(1'b1);
`ifdef EX_MEM_FWD_EN
    chk("fwd_addr", {27'd0, fwd_addr_o}, 32'd7);
    chk("fwd_skid_addr", {27'd0, fwd_skid_addr_o}, 32'd9);
    chk("fwd_we", {30'd0, fwd_we_o, fwd_skid_we_o}, 32'd3);
`endif
    flush_i = 1'b1;
    drive(1'b1, 32'h408, 1'b1, 5'd11, 32'h56);
    cycle(1'b1);
    flush_i = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("flush_valid", {31'd0, mem_valid_o}, 32'd0);
    chk("flush_ready", {31'd0, ex_ready_o}, 32'd1);
    mem_ready_i = 1'b1;
    cycle(1'b1);
    chk("flush_no_beat", {31'd0, mem_valid_o}, 32'd0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 1500; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      flush_i     = ($urandom_range(0, 29) == 0);
      mem_ready_i = ($urandom_range(0, 9) < 6);
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom);
      cycle(1'b1);
    end

    // Saturation of the stall counter.
    rst_n = 1'b1; flush_i = 1'b0; mem_ready_i = 1'b0;
    drive(1'b1, 32'h500, 1'b1, 5'd4, 32'h77);
    cycle(1'b1);
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 70000; i++) cycle(1'b0);
    check_model();
    chk("stall_sat", {16'd0, stall_cnt_o}, 32'h0000FFFF);
    rst_n = 1'b0;
    cycle(1'b1);
    chk("stall_rst", {16'd0, stall_cnt_o}, 32'd0);
    chk("rst_mid_valid", {31'd0, mem_valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_buf.md
EX_MEM_BUF -- requirements
Module: ex_mem_buf

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: ex_valid_i  in  1  exu result beat valid.
REQ-004 SHALL have ports: ex_ready_o  out  1  buffer can accept a beat.
REQ-005 SHALL have ports: pc_i  in  32  pc of the exu instruction.
REQ-006 SHALL have ports: rd_we_i  in  1; rd_addr_i  in  `REG_ADDR_BUS (5); rd_data_i  in  `REG_BUS (32)  exu writeback request.
REQ-007 SHALL have ports: flush_i  in  1  discard all buffered and incoming beats.
REQ-008 SHALL have ports: mem_valid_o  out  1; mem_ready_i  in  1  handshake toward mem.
REQ-009 SHALL have ports: pc_o  out  32; rd_we_o  out  1; rd_addr_o  out  5; rd_data_o  out  32  head beat toward mem.
REQ-010 SHALL have ports: stall_cnt_o  out  16  saturating mem back-pressure cycle count.

Function
REQ-011 Storage SHALL be two entries: main (drives outputs) and skid; entry = {pc, we, addr, data}.
REQ-012 ex_ready_o SHALL equal NOT skid_valid, driven from a register (no combinational path from mem_ready_i).
REQ-013 Accept SHALL be ex_valid_i AND ex_ready_o AND NOT flush_i; pop SHALL be mem_valid_o AND mem_ready_i.
REQ-014 mem_valid_o SHALL equal main_valid; pc_o/rd_addr_o/rd_data_o SHALL show main entry, holding last value when main invalid.
REQ-015 rd_we_o SHALL be main_valid AND main.we AND (main.addr != 0); x0 writes pass through with we cleared.
REQ-016 Skid valid, pop: main<=skid, skid_valid<=0 (accept impossible).
REQ-017 Skid empty, accept, (main empty OR pop): main<=input, main_valid<=1; latency input to mem_valid_o = 1 cycle.
REQ-018 Skid empty, accept, main valid, no pop: skid<=input, skid_valid<=1; ex_ready_o low next cycle.
REQ-019 Skid empty, no accept, pop: main_valid<=0.
REQ-020 Beat order SHALL be preserved; no beat dropped or duplicated except by flush.
REQ-021 flush_i SHALL clear main_valid and skid_valid next cycle, take priority over accept and pop, and discard the same-cycle input beat.
REQ-022 stall_cnt_o SHALL increment by 1 each cycle with mem_valid_o=1 and mem_ready_i=0, saturate at 16'hFFFF, unaffected by flush.

Reset
REQ-023 When rst_n=0 at a rising edge: main_valid=0, skid_valid=0, all entry fields=0, stall_cnt_o=0.
REQ-024 During and the cycle after reset: mem_valid_o=0, rd_we_o=0, rd_addr_o=0, rd_data_o=0, pc_o=0, ex_ready_o=1.
REQ-025 Reset mid-transfer SHALL drop both entries without completing any handshake.

Configuration
REQ-026 Macro EX_MEM_FWD_EN defined: SHALL add outputs fwd_we_o (1), fwd_addr_o (5), fwd_data_o (32) equal to rd_we_o, rd_addr_o, rd_data_o, plus skid-entry forwarding (fwd_skid_we_o, fwd_skid_addr_o, fwd_skid_data_o) with the same x0 rule, for id-stage bypass.
REQ-027 Macro EX_MEM_FWD_EN undefined: forwarding ports SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset, then beat {pc=0x100, we=1, addr=5, data=0xA5A5A5A5}, mem_ready_i=1 -> next cycle mem_valid_o=1, rd_we_o=1, rd_addr_o=5, rd_data_o=0xA5A5A5A5; gone cycle after.
REQ-029 mem_ready_i=0, three back-to-back beats data=1,2,3 -> first two accepted, ex_ready_o=0 from 2nd cycle, stall_cnt_o counts; raise mem_ready_i -> mem receives 1,2,3 in order.
REQ-030 Beat with we=1, addr=0, data=0xFFFFFFFF -> mem_valid_o=1, rd_we_o=0, rd_addr_o=0.
REQ-031 Both entries full, flush_i=1 with ex_valid_i=1 -> next cycle mem_valid_o=0, ex_ready_o=1; incoming beat never appears.
REQ-032 mem_ready_i held 0 for 70000 cycles with main valid -> stall_cnt_o=0xFFFF, no wrap; rst_n=0 -> 0.
REQ-033 With EX_MEM_FWD_EN, main {addr=7, data=0x12}, skid {addr=9, data=0x34} -> fwd_addr_o=7, fwd_skid_addr_o=9, both we=1.
